// File: rtl/timebin_pkg.sv
// Shared types and helpers for the PMT timebin trigger generator.
package timebin_pkg;

  // Run-control states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // 100 us bin unit at a 50 MHz system clock
  localparam int DEF_CLK_PER_UNIT = 5000;

  // Width that holds factor * clk_per_unit without truncation
  function automatic int len_width(input int clk_per_unit, input int factor_w);
    return $clog2(clk_per_unit) + factor_w;
  endfunction

endpackage

// File: rtl/timebin_trigger_gen_snap_holding_reg.sv
// One-entry valid/ready holding register for bin snapshots. A new
// snapshot is accepted when the slot is empty or is being drained in the
// same cycle; otherwise it is dropped and a sticky overrun flag is set.
module snap_holding_reg #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [NUM_CH*CNT_W-1:0] load_data,
  input  logic [IDX_W-1:0]        load_idx,
  input  logic                    clr_overrun,
  input  logic                    ready,
  output logic                    valid,
  output logic [NUM_CH*CNT_W-1:0] data,
  output logic [IDX_W-1:0]        idx,
  output logic                    overrun
);

  logic             valid_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             overrun_reg;
  logic [CNT_W-1:0] lane_reg [NUM_CH];
  logic             take;

  // Slot is free if empty or the consumer takes the current entry now
  assign take = load && (!valid_reg || ready);

  // Valid flag, bin index and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg   <= 1'b0;
      idx_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (take) begin
        valid_reg <= 1'b1;
        idx_reg   <= load_idx;
      end else if (valid_reg && ready) begin
        valid_reg <= 1'b0;
      end
      if (clr_overrun) begin
        overrun_reg <= 1'b0;
      end else if (load && !take) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  // Per-channel count lanes, held stable until the next accepted load
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          lane_reg[gi] <= '0;
        end else if (take) begin
          lane_reg[gi] <= load_data[gi*CNT_W +: CNT_W];
        end
      end
      assign data[gi*CNT_W +: CNT_W] = lane_reg[gi];
    end
  endgenerate

  assign valid   = valid_reg;
  assign idx     = idx_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/timebin_trigger_gen.sv
// Timebin generator: runs bins of factor * CLK_PER_UNIT cycles, snapshots
// the channel counters at each bin end, clears them, and hands snapshots
// to the packer. Handles start/stop, bin-count limit and factor changes.
module timebin_trigger_gen
  import timebin_pkg::*;
#(
  parameter int CLK_PER_UNIT = DEF_CLK_PER_UNIT,
  parameter int FACTOR_W     = 8,
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int BINS_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [FACTOR_W-1:0]     factor,
  input  logic [BINS_W-1:0]       num_bins,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NUM_CH*CNT_W-1:0] cnt_in,
  output logic                    cnt_clr,
  output logic [NUM_CH*CNT_W-1:0] snap_data,
  output logic                    snap_valid,
  input  logic                    snap_ready,
  output logic [BINS_W-1:0]       bin_idx,
  output logic                    running,
  output logic                    overrun,
  output logic [FACTOR_W-1:0]     factor_out
);

  localparam int LEN_W = len_width(CLK_PER_UNIT, FACTOR_W);

  state_t              state_reg, state_next;
  logic                start_q_reg;
  logic [LEN_W-1:0]    count_reg;
  logic [LEN_W-1:0]    len_m1_reg;
  logic [FACTOR_W-1:0] factor_reg;
  logic [BINS_W-1:0]   bin_reg;
  logic                cnt_clr_reg;

  logic start_rise;
  logic run_start;
  logic factor_chg;
  logic terminal;
  logic last_bin;

  // Last count of a bin; the multiply runs at full product width
  function automatic logic [LEN_W-1:0] len_m1(input logic [FACTOR_W-1:0] f);
    return LEN_W'(f) * LEN_W'(CLK_PER_UNIT) - LEN_W'(1);
  endfunction

  assign start_rise = start && !start_q_reg;

  // Run-control events decoded from the current state and inputs
  always_comb begin
    run_start  = (state_reg == ST_IDLE) && start_rise && (factor != '0);
    factor_chg = (state_reg == ST_RUN) && (factor != factor_reg);
    terminal   = (state_reg == ST_RUN) && !factor_chg && (count_reg == len_m1_reg);
    last_bin   = (num_bins != '0) && (bin_reg >= num_bins - BINS_W'(1));
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: stop, bin limit or a zero factor end the run
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (run_start) state_next = ST_RUN;
      ST_RUN: begin
        if (stop || (terminal && last_bin) || (factor_chg && factor == '0)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    running = (state_reg == ST_RUN);
  end

  // Bin timing datapath: cycle counter, latched factor, bin index, clear pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q_reg <= 1'b0;
      count_reg   <= '0;
      len_m1_reg  <= '0;
      factor_reg  <= '0;
      bin_reg     <= '0;
      cnt_clr_reg <= 1'b0;
    end else begin
      start_q_reg <= start;
      cnt_clr_reg <= 1'b0;
      if (run_start) begin
        factor_reg  <= factor;
        len_m1_reg  <= len_m1(factor);
        count_reg   <= '0;
        bin_reg     <= '0;
        cnt_clr_reg <= 1'b1;
      end else if (state_reg == ST_RUN) begin
        if (terminal) begin
          count_reg   <= '0;
          bin_reg     <= bin_reg + BINS_W'(1);
          cnt_clr_reg <= 1'b1;
        end else if (stop) begin
          // partial bin is abandoned: no snapshot and no counter clear
          count_reg <= count_reg;
        end else if (factor_chg) begin
          factor_reg  <= factor;
          len_m1_reg  <= len_m1(factor);
          count_reg   <= '0;
          cnt_clr_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + LEN_W'(1);
        end
      end
    end
  end

  snap_holding_reg #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .IDX_W  (BINS_W)
  ) u_hold (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (terminal),
    .load_data   (cnt_in),
    .load_idx    (bin_reg),
    .clr_overrun (run_start),
    .ready       (snap_ready),
    .valid       (snap_valid),
    .data        (snap_data),
    .idx         (bin_idx),
    .overrun     (overrun)
  );

  assign cnt_clr    = cnt_clr_reg;
  assign factor_out = factor_reg;

endmodule

// File: tb/tb_timebin_trigger_gen.sv
// Scoreboard bench for timebin_trigger_gen with a bin-arithmetic reference model.
module tb_timebin_trigger_gen;

  localparam int CPU = 10;
  localparam int FW  = 8;
  localparam int NCH = 2;
  localparam int CW  = 16;
  localparam int BW  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [FW-1:0]     factor = '0;
  logic [BW-1:0]     num_bins = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [NCH*CW-1:0] cnt_in = '0;
  logic              cnt_clr;
  logic [NCH*CW-1:0] snap_data;
  logic              snap_valid;
  logic              snap_ready = 1'b0;
  logic [BW-1:0]     bin_idx;
  logic              running;
  logic              overrun;
  logic [FW-1:0]     factor_out;

  timebin_trigger_gen #(
    .CLK_PER_UNIT (CPU),
    .FACTOR_W     (FW),
    .NUM_CH       (NCH),
    .CNT_W        (CW),
    .BINS_W       (BW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .factor     (factor),
    .num_bins   (num_bins),
    .start      (start),
    .stop       (stop),
    .cnt_in     (cnt_in),
    .cnt_clr    (cnt_clr),
    .snap_data  (snap_data),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .bin_idx    (bin_idx),
    .running    (running),
    .overrun    (overrun),
    .factor_out (factor_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH*CW-1:0] data;
    logic [BW-1:0]     idx;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  // reference model state (state after the most recent clock edge)
  bit            m_run, m_valid, m_clr, m_ovr, m_start_q;
  logic [FW-1:0] m_fout;
  logic [BW-1:0] m_bin;
  int            m_elapsed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: compare DUT against the model, then predict the coming edge
  always @(negedge clk) begin
    bit start_rise, fchg, term, hs, nclr;
    if (!reset_n) begin
      m_run = 0; m_valid = 0; m_clr = 0; m_ovr = 0; m_start_q = 0;
      m_fout = '0; m_bin = '0; m_elapsed = 0;
      exp_q.delete();
    end else begin
      check("running", running, m_run);
      check("snap_valid", snap_valid, m_valid);
      check("cnt_clr", cnt_clr, m_clr);
      check("overrun", overrun, m_ovr);
      check("factor_out", factor_out, m_fout);
      start_rise = start && !m_start_q;
      hs   = m_valid && snap_ready;
      nclr = 0;
      if (!m_run) begin
        if (start_rise && factor != 0) begin
          m_run = 1; m_fout = factor; m_elapsed = 0; m_bin = '0; m_ovr = 0; nclr = 1;
        end
      end else begin
        fchg = (factor != m_fout);
        term = !fchg && (m_elapsed + 1 == int'(m_fout) * CPU);
        if (term) begin
          if (!m_valid || snap_ready) begin
            exp_q.push_back('{data: cnt_in, idx: m_bin});
            m_valid = 1;
            hs = 0;
          end else begin
            m_ovr = 1;
          end
          nclr = 1;
          m_elapsed = 0;
          m_bin = m_bin + 1'b1;
          if (stop || (num_bins != 0 && m_bin >= num_bins)) m_run = 0;
        end else if (stop) begin
          m_run = 0;
        end else if (fchg) begin
          m_fout = factor; m_elapsed = 0; nclr = 1;
          if (factor == 0) m_run = 0;
        end else begin
          m_elapsed++;
        end
      end
      if (hs) m_valid = 0;
      m_clr = nclr;
      m_start_q = start;
    end
  end

  // Monitor: every handshake pops the oldest expected snapshot
  always @(negedge clk) begin
    snap_t e;
    if (reset_n && snap_valid && snap_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        check("snap_unexpected", 64'(snap_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("snap_data", snap_data, e.data);
        check("snap_bin_idx", bin_idx, e.idx);
        $display("snap idx=%0d data=%08h", bin_idx, snap_data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cnt_in = $urandom;
    end
  endtask

  // Bounded wait for snap_valid; returns the number of edges taken
  task automatic cycles_to_valid(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!snap_valid && n < 200);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic end_run();
    stop = 1'b1; step(1); stop = 1'b0;
    snap_ready = 1'b1; step(3);
  endtask

  int n, h0;

  initial begin
    #2;
    check("rst_running", running, 0);
    check("rst_valid", snap_valid, 0);
    check("rst_clr", cnt_clr, 0);
    check("rst_factor_out", factor_out, 0);
    check("rst_bin_idx", bin_idx, 0);
    step(3);
    reset_n = 1'b1;
    step(2);

    // free run, factor 3: first snapshot latency and bin spacing
    factor = 3; num_bins = 0; snap_ready = 1'b1;
    start = 1'b1;
    cycles_to_valid(n);
    check("first_latency", n, 31);
    check("bin_idx0", bin_idx, 0);
    cycles_to_valid(n);
    check("bin_spacing1", n, 30);
    check("bin_idx1", bin_idx, 1);
    cycles_to_valid(n);
    check("bin_spacing2", n, 30);
    check("bin_idx2", bin_idx, 2);
    start = 1'b0;
    end_run();

    // bin limit of 4
    factor = 2; num_bins = 4; h0 = hs_count;
    pulse_start();
    step(100);
    check("limit_snaps", hs_count - h0, 4);
    check("limit_running", running, 0);
    num_bins = 0;

    // back-pressure across two bins
    factor = 1; snap_ready = 1'b0;
    pulse_start();
    step(25);
    check("hold_overrun", overrun, 1);
    check("hold_bin_idx", bin_idx, 0);
    check("hold_qsize", exp_q.size(), 1);
    if (exp_q.size() > 0) check("hold_data", snap_data, exp_q[0].data);
    snap_ready = 1'b1;
    step(2);
    end_run();

    // stop 5 cycles into bin 1
    factor = 2; h0 = hs_count;
    pulse_start();
    step(24);
    stop = 1'b1; step(1); stop = 1'b0;
    check("stop_mid_running", running, 0);
    step(30);
    check("stop_mid_snaps", hs_count - h0, 1);

    // stop on the terminal cycle of bin 0
    h0 = hs_count;
    pulse_start();
    step(19);
    stop = 1'b1; step(1); stop = 1'b0;
    check("stop_term_running", running, 0);
    check("stop_term_valid", snap_valid, 1);
    step(3);
    check("stop_term_snaps", hs_count - h0, 1);

    // factor change mid-bin, then factor to zero
    factor = 3;
    pulse_start();
    step(10);
    factor = 5; step(1);
    check("fchg_factor_out", factor_out, 5);
    cycles_to_valid(n);
    check("fchg_latency", n, 50);
    check("fchg_bin_idx", bin_idx, 0);
    factor = 0; step(2);
    check("fzero_running", running, 0);

    // start ignored with factor zero
    pulse_start();
    step(5);
    check("f0_start_running", running, 0);

    // randomized run control
    factor = 2;
    for (int i = 0; i < 3000; i++) begin
      snap_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) factor = FW'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) num_bins = BW'($urandom_range(0, 5));
      step(1);
    end
    start = 1'b0; factor = 2; num_bins = 0;
    end_run();

    // asynchronous reset mid-run with a held snapshot
    snap_ready = 1'b0;
    pulse_start();
    step(45);
    check("pre_rst_valid", snap_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_running", running, 0);
    check("arst_valid", snap_valid, 0);
    check("arst_overrun", overrun, 0);
    check("arst_clr", cnt_clr, 0);
    check("arst_factor_out", factor_out, 0);
    check("arst_data", snap_data, 0);
    step(2);
    reset_n = 1'b1;
    step(5);
    check("post_rst_running", running, 0);

    snap_ready = 1'b1;
    step(5);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
